// File: rtl/regdump_pkg.sv
// Shared types and sizing helpers for the register-file dump reader.
// Consumers: regdump_serializer, regfile_dump.
package regdump_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StCksum,
    StDone
  } state_e;

  localparam int unsigned DEF_DW = 32;

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

  // Counter width for n states; never zero so a single-byte word still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEF_DW);
  localparam int unsigned BCNT_W         = cnt_width(BYTES_PER_WORD);

endpackage

// File: rtl/regdump_serializer.sv
// Holds one DW-bit word and emits it LSB-first as bytes over valid/ready.
// last_o flags the handshake of the final byte of the word.
module regdump_serializer
  import regdump_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] word_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [7:0]    data_o,
  output logic          last_o
);

  localparam int unsigned Bpw = bytes_per_word(DW);
  localparam int unsigned Bw  = cnt_width(Bpw);
  localparam logic [Bw-1:0] LastByte = Bw'(Bpw - 1);

  logic [DW-1:0] word_q, word_d;
  logic [Bw-1:0] bcnt_q, bcnt_d;
  logic          valid_q, valid_d;
  logic          hs;

  assign hs      = valid_q & ready_i;
  assign last_o  = hs & (bcnt_q == LastByte);
  assign valid_o = valid_q;
  assign data_o  = word_q[7:0];

  always_comb begin
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      bcnt_d  = '0;
      valid_d = 1'b1;
    end else if (hs) begin
      word_d = word_q >> 8;
      bcnt_d = bcnt_q + 1'b1;
      if (bcnt_q == LastByte) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q  <= '0;
      bcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks register indices 0..NREGS-1 through the register-file test port and streams each word
// out LSB-first as bytes. Optional trailing XOR checksum byte: define REGDUMP_CKSUM_EN.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned SELW  = 5,
  parameter int unsigned DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [SELW-1:0] sel_o,
  input  logic [DW-1:0]   sel_d_i,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
);

  localparam logic [SELW-1:0] LastSel = SELW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;

  logic            ser_valid;
  logic [7:0]      ser_data;
  logic            ser_last;

`ifdef REGDUMP_CKSUM_EN
  logic [7:0]      cks_q, cks_d;
  logic            cks_valid_q, cks_valid_d;
`endif

  regdump_serializer #(
    .DW(DW)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .word_i (sel_d_i),
    .ready_i(tx_ready),
    .valid_o(ser_valid),
    .data_o (ser_data),
    .last_o (ser_last)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef REGDUMP_CKSUM_EN
    cks_d       = cks_q;
    cks_valid_d = cks_valid_q;
    if (ser_valid && tx_ready) begin
      cks_d = cks_q ^ ser_data;
    end
`endif
    unique case (state_q)
      StIdle: begin
        sel_d = '0;
        if (start) begin
          state_d = StLoad;
          busy_d  = 1'b1;
`ifdef REGDUMP_CKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      StLoad: begin
        // Register file read is asynchronous, so the word is valid in the same cycle as sel_q.
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (ser_last) begin
          if (sel_q == LastSel) begin
`ifdef REGDUMP_CKSUM_EN
            state_d     = StCksum;
            cks_valid_d = 1'b1;
`else
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
`ifdef REGDUMP_CKSUM_EN
      StCksum: begin
        if (tx_ready) begin
          cks_valid_d = 1'b0;
          state_d     = StDone;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
        sel_d   = '0;
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGDUMP_CKSUM_EN
      cks_q       <= '0;
      cks_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGDUMP_CKSUM_EN
      cks_q       <= cks_d;
      cks_valid_q <= cks_valid_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sel_o = sel_q;

`ifdef REGDUMP_CKSUM_EN
  assign tx_valid = ser_valid | cks_valid_q;
  assign tx_data  = cks_valid_q ? cks_q : ser_data;
`else
  assign tx_valid = ser_valid;
  assign tx_data  = ser_data;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed sequence with randomized data and back-pressure,
// checked against a byte-stream model built from the register contents.
module tb_regfile_dump;

  localparam int unsigned NREGS = 32;
  localparam int unsigned SELW  = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned BPW   = DW / 8;
`ifdef REGDUMP_CKSUM_EN
  localparam int unsigned CKB = 1;
`else
  localparam int unsigned CKB = 0;
`endif
  // Edges from the one that samples start to the one that raises done.
  localparam int DONE_AT = NREGS * (1 + BPW) + CKB;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [SELW-1:0] sel_o;
  logic [DW-1:0]   sel_d_i;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;

  logic [DW-1:0] rf   [NREGS];
  logic [DW-1:0] gold [NREGS];
  logic [7:0]    got   [$];
  logic [7:0]    exp_q [$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  assign sel_d_i = rf[sel_o];

  regfile_dump #(
    .NREGS(NREGS),
    .SELW (SELW),
    .DW   (DW)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .sel_o   (sel_o),
    .sel_d_i (sel_d_i),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: collects accepted bytes, counts done pulses, checks stall hold.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_data", 32'(tx_data), 32'(prev_data));
    end
    prev_stall <= rst && tx_valid && !tx_ready;
    prev_data  <= tx_data;
    if (rst && tx_valid && tx_ready) got.push_back(tx_data);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic build_expected();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    for (int i = 0; i < int'(NREGS); i++) begin
      for (int b = 0; b < int'(BPW); b++) begin
        exp_q.push_back(gold[i][8*b +: 8]);
        x = x ^ gold[i][8*b +: 8];
      end
    end
    if (CKB != 0) exp_q.push_back(x);
  endtask

  task automatic compare_stream();
    check("byte_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic run_dump(input bit rnd, input int restart_at, input bit poke);
    int n;
    int busy_bad;
    bit seen;
    bit poked;
    n = 0;
    busy_bad = 0;
    seen = 1'b0;
    poked = 1'b0;
    got.delete();
    done_cnt = 0;
    tx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!seen && n < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (n == restart_at);
      if (poke && !poked && sel_o == 5'd3 && tx_valid) begin
        rf[5] = 32'hDEADBEEF;
        poked = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_bad++;
        if (!rnd && n == 0) check("load_cycle_valid", 32'(tx_valid), 32'd0);
        if (!rnd && n == 1) check("first_byte_valid", 32'(tx_valid), 32'd1);
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (!rnd) check("done_cycle", 32'(n), 32'(DONE_AT));
    check("busy_at_done", 32'(busy), 32'd0);
    check("busy_gaps", 32'(busy_bad), 32'd0);
    start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sel", 32'(sel_o), 32'd0);
    check("idle_valid", 32'(tx_valid), 32'd0);
    compare_stream();
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < int'(NREGS); i++) rf[i] = 32'h01020300 + 32'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(NREGS); i++) rf[i] = $urandom;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < int'(NREGS); i++) rf[i] = '0;
  endtask

  task automatic snap_gold();
    for (int i = 0; i < int'(NREGS); i++) gold[i] = rf[i];
  endtask

  initial begin
    int k;
    rst = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    fill_zero();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_sel", 32'(sel_o), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Counting pattern, sink always ready: exact timing and byte order.
    fill_pattern();
    snap_gold();
    build_expected();
    check("exp_first", 32'(exp_q[0]), 32'h00);
    run_dump(1'b0, -1, 1'b0);

    // Same pattern under random back-pressure.
    run_dump(1'b1, -1, 1'b0);

    // Second start pulse mid-dump must be ignored.
    run_dump(1'b0, 20, 1'b0);

    // Reset while register 7 byte 2 is on the bus.
    got.delete();
    done_cnt = 0;
    tx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (got.size() != 30 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_mid_reached", 32'(got.size()), 32'd30);
    check("rst_mid_sel", 32'(sel_o), 32'd7);
    check("rst_mid_data", 32'(tx_data), 32'(rf[7][23:16]));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_sel0", 32'(sel_o), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);

    // Fresh dump after reset starts at register 0.
    fill_random();
    snap_gold();
    build_expected();
    run_dump(1'b0, -1, 1'b0);

    // Register 5 rewritten while register 3 streams: snapshot taken at register 5's load.
    fill_random();
    rf[3] = '0;
    snap_gold();
    gold[5] = 32'hDEADBEEF;
    build_expected();
    run_dump(1'b0, -1, 1'b1);

    // Random contents with random back-pressure.
    fill_random();
    snap_gold();
    build_expected();
    run_dump(1'b1, -1, 1'b0);

    // Checksum patterns.
    fill_zero();
    rf[1] = 32'h000000A5;
    rf[2] = 32'h0000005A;
    snap_gold();
    build_expected();
    run_dump(1'b0, -1, 1'b0);
`ifdef REGDUMP_CKSUM_EN
    if (got.size() > 0) check("cksum_ff", 32'(got[got.size()-1]), 32'hFF);
`endif
    fill_zero();
    snap_gold();
    build_expected();
    run_dump(1'b1, -1, 1'b0);
`ifdef REGDUMP_CKSUM_EN
    if (got.size() > 0) check("cksum_00", 32'(got[got.size()-1]), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug/SoC-test reader for the CPU register file.
- On a start pulse it walks register indices 0..NREGS-1 through the register file's select/read test port.
- It snapshots each 32-bit word and streams it out as bytes, LSB first, over a valid/ready byte interface feeding the UART TX.
- Lets the host dump architectural register state without halting the fetch path.

Parameters:
- NREGS, 32: number of registers dumped; indices 0..NREGS-1.
- SELW, 5: width of the register select; NREGS <= 2**SELW.
- DW, 32: register data width; must be a multiple of 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (reset when rst==0).
- start  in  1  one-cycle request to begin a dump; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final byte is accepted.
- sel_o  out  SELW  register index driven to the register file select port (registered).
- sel_d_i  in  DW  register file read data for sel_o (combinational/asynchronous read).
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high.

Behaviour:
- Reset values:
  - State IDLE; busy=0, done=0, tx_valid=0.
  - tx_data=0, sel_o=0; index, byte counter and shift register all 0.
- States and transitions:
  - IDLE: on start, go to LOAD with sel_o=0. busy rises the next cycle.
  - LOAD: one cycle. Capture word<=sel_d_i and bcnt<=0; go to SEND.
  - SEND: tx_valid=1, tx_data=word[7:0].
    - On handshake: word>>=8, bcnt++.
    - On the handshake with bcnt==DW/8-1:
      - If sel_o==NREGS-1, go to DONE (or CKSUM when the optional feature is enabled).
      - Otherwise sel_o<=sel_o+1 and go to LOAD.
  - DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Handshake rules:
  - Once tx_valid is asserted, tx_valid and tx_data hold stable until accepted.
  - tx_valid never depends combinationally on tx_ready.
- Latency:
  - The first byte is valid 2 cycles after the start edge (IDLE->LOAD->SEND).
  - With tx_ready tied high, each word costs 1+DW/8 cycles: 160 cycles for the default config, plus the start and DONE cycles.
- Snapshot semantics:
  - Each word is sampled in its own LOAD cycle. Writes to a register after its LOAD are not reflected.
  - The dump is not atomic across registers.
- Boundaries:
  - start during busy or DONE: ignored, not queued.
  - tx_ready low indefinitely: block stalls in SEND with outputs held.
  - Reset mid-dump: return to IDLE on the next edge. tx_valid drops immediately, no done pulse, partial output abandoned.
  - NREGS==1: a single LOAD/SEND pass, then DONE.
  - sel_o wraps to 0 on return to IDLE; it never exceeds NREGS-1.

Optional Feature:
- Macro: REGDUMP_CKSUM_EN.
- Defined:
  - An 8-bit running XOR of every accepted data byte is kept; it clears in IDLE on start.
  - After the last data byte, state CKSUM presents tx_data=checksum with tx_valid=1 and the same hold rules.
  - On handshake, go to DONE.
  - Total stream is NREGS*DW/8+1 bytes.
- Undefined:
  - No CKSUM state and no checksum register.
  - Stream is exactly NREGS*DW/8 bytes.

Decomposition:
- Package regdump_pkg:
  - State enum (IDLE, LOAD, SEND, CKSUM, DONE).
  - BYTES_PER_WORD = DW/8.
  - Byte-counter width constant.
- One natural sub-module, regdump_serializer:
  - Loads a DW-bit word and emits DW/8 bytes LSB-first with valid/ready.
  - Signals last-byte-accepted back to the FSM.
- Top level keeps the index counter, FSM, done/busy generation and optional checksum.

Test Plan:
- Reset, then start with tx_ready=1 and RF[i]=32'h01020300+i -> 128 bytes 00,03,02,01,01,03,02,01,...,1F,03,02,01. done pulses exactly once, 162 cycles after start; busy high throughout.
- tx_ready toggled pseudo-randomly (about 50%) -> identical byte sequence; tx_data never changes while tx_valid=1 and tx_ready=0.
- start pulsed again at cycle 20 of an active dump -> ignored; exactly 128 bytes and one done.
- rst driven low while sending register 7, byte 2 -> next cycle IDLE, tx_valid=0, busy=0, no done. A fresh start then dumps from register 0.
- RF[5] written to 32'hDEADBEEF while register 3 is being sent, RF[3]=0 -> register 3 bytes are 00, register 5 bytes are EF,BE,AD,DE.
- With REGDUMP_CKSUM_EN, all RF=0 except RF[1]=32'h000000A5 and RF[2]=32'h0000005A -> 129th byte is 8'hFF; all RF=0 -> 129th byte is 8'h00.
